// File: rtl/fwft_bram_fifo_pkg.sv
// Shared defaults and width helpers for the FWFT block-RAM FIFO.
package fwft_bram_fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_MAX_DEPTH  = 1000000;

  // Address width for a memory of the given depth; never narrower than one bit.
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fwft_bram_fifo_if.sv
// Producer/consumer handshake bundle for the FWFT FIFO.
interface fwft_bram_fifo_if
  import fwft_bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  nearly_full;
  logic                  recieve_more_than_0;
  logic                  recieve_more_than_1;

  modport master (
    output din, wr_en, rd_en,
    input  dout, full, nearly_full, recieve_more_than_0, recieve_more_than_1
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, nearly_full, recieve_more_than_0, recieve_more_than_1
  );

endinterface

// File: rtl/fwft_bram_fifo_sdp_bram.sv
// Simple dual-port RAM: one write port, one synchronous read port, no reset.
module fwft_bram_fifo_sdp_bram
  import fwft_bram_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter  int unsigned DEPTH      = DEFAULT_MAX_DEPTH,
  localparam int unsigned AW         = addr_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-before-write on a same-address collision; the caller bypasses that case.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= din;
    end
    dout <= mem[rd_addr];
  end

endmodule

// File: rtl/fwft_bram_fifo.sv
// First-word-fall-through FIFO over a synchronous-read block RAM.
// The RAM is pre-read at the next head address so the head word is on dout
// the edge after it is written or after the previous head is popped.
module fwft_bram_fifo
  import fwft_bram_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH                    = DEFAULT_DATA_WIDTH,
  parameter int unsigned MAX_DEPTH                     = DEFAULT_MAX_DEPTH,
  parameter bit          IGNORE_SAME_LOC_RD_WR_WARNING = 1'b0
) (
  input logic              clk,
  input logic              reset,
  fwft_bram_fifo_if.slave  bus
);

  localparam int unsigned    AW       = addr_width(MAX_DEPTH);
  localparam int unsigned    CW       = $clog2(MAX_DEPTH + 1);
  localparam logic [AW-1:0]  LAST_PTR = AW'(MAX_DEPTH - 1);

  // Pointer increment with an explicit wrap, so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + AW'(1);
  endfunction

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         ra;
  logic [CW-1:0]         count;
  logic [CW-1:0]         count_next;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  bypass;
  logic                  bypass_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  full_q;
  logic                  nearly_full_q;
  logic                  more_than_0_q;
  logic                  more_than_1_q;

  // Qualify requests against registered state and pick the RAM read address.
  always_comb begin
    wr_ok      = bus.wr_en & ~full_q;
    rd_ok      = bus.rd_en & (count != '0);
    ra         = rd_ok ? next_ptr(rd_ptr) : rd_ptr;
    bypass     = wr_ok & (wr_ptr == ra);
    count_next = count;
    if (wr_ok && !rd_ok) begin
      count_next = count + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_next = count - CW'(1);
    end
  end

  // Pointers, occupancy and status flags (flags registered from next count).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      full_q        <= 1'b0;
      nearly_full_q <= 1'b0;
      more_than_0_q <= 1'b0;
      more_than_1_q <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= next_ptr(wr_ptr);
      if (rd_ok) rd_ptr <= next_ptr(rd_ptr);
      count         <= count_next;
      full_q        <= (count_next == CW'(MAX_DEPTH));
      nearly_full_q <= (count_next >= CW'(MAX_DEPTH - 1));
      more_than_0_q <= (count_next != '0);
      more_than_1_q <= (count_next > CW'(1));
    end
  end

  // Same-address bypass register; reset selects a zeroed din_q so dout reads 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bypass_q <= 1'b1;
      din_q    <= '0;
    end else begin
      bypass_q <= bypass;
      if (bypass) din_q <= bus.din;
    end
  end

  fwft_bram_fifo_sdp_bram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr),
    .din     (bus.din),
    .rd_addr (ra),
    .dout    (ram_q)
  );

  assign bus.dout                = bypass_q ? din_q : ram_q;
  assign bus.full                = full_q;
  assign bus.nearly_full         = nearly_full_q;
  assign bus.recieve_more_than_0 = more_than_0_q;
  assign bus.recieve_more_than_1 = more_than_1_q;

`ifdef FWFT_BRAM_FIFO_SIM_MSGS
  // Simulation-only notice of a write into a full FIFO.
  always @(posedge clk) begin
    if (!reset && bus.wr_en && full_q)
      $display("fwft_bram_fifo %m: write dropped while full at %0t", $time);
  end
`endif

  if (IGNORE_SAME_LOC_RD_WR_WARNING == 1'b0) begin : g_same_loc_note
`ifdef FWFT_BRAM_FIFO_SIM_MSGS
    // Simulation-only notice when a write lands on the address being read.
    always @(posedge clk) begin
      if (!reset && bypass)
        $display("fwft_bram_fifo %m: same-location read/write at %0t, bypassing", $time);
    end
`endif
  end

endmodule

// File: tb/tb_fwft_bram_fifo.sv
// Directed bench for fwft_bram_fifo with a queue-based reference model.
module tb_fwft_bram_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 5;

  logic clk = 1'b0;
  logic reset;

  fwft_bram_fifo_if #(.DATA_WIDTH(DW)) bus ();

  fwft_bram_fifo #(
    .DATA_WIDTH                    (DW),
    .MAX_DEPTH                     (DEPTH),
    .IGNORE_SAME_LOC_RD_WR_WARNING (1'b0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model [$];
  bit run_cmp = 1'b0;

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endfunction

  // One clock of stimulus; the model applies the FIFO rules at the same edge.
  task automatic cycle(input bit we, input logic [DW-1:0] d, input bit re);
    bit wok;
    bit rok;
    bus.wr_en = we;
    bus.din   = d;
    bus.rd_en = re;
    @(posedge clk);
    wok = we && (model.size() != DEPTH);
    rok = re && (model.size() != 0);
    if (rok) void'(model.pop_front());
    if (wok) model.push_back(d);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  // Every falling edge: flags against model occupancy, head word when non-empty.
  always @(negedge clk) begin
    int n;
    if (run_cmp) begin
      n = model.size();
      check("full",        32'(bus.full),                32'(n == DEPTH));
      check("nearly_full", 32'(bus.nearly_full),         32'(n >= DEPTH - 1));
      check("more_than_0", 32'(bus.recieve_more_than_0), 32'(n > 0));
      check("more_than_1", 32'(bus.recieve_more_than_1), 32'(n > 1));
      if (reset)
        check("dout_reset", 32'(bus.dout), 32'h0);
      else if (n > 0)
        check("dout_head", 32'(bus.dout), 32'(model[0]));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    bus.din   = '0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #1 reset = 1'b1;
    #1 run_cmp = 1'b1;

    // Reset held, then released; read while empty changes nothing.
    repeat (2) @(posedge clk);
    #1;
    check("t1_m0_in_reset",   32'(bus.recieve_more_than_0), 32'h0);
    check("t1_dout_in_reset", 32'(bus.dout),                32'h0);
    reset = 1'b0;
    #1;
    check("t1_full_after", 32'(bus.full), 32'h0);
    check("t1_dout_after", 32'(bus.dout), 32'h0);
    cycle(1'b0, '0, 1'b1);
    check("t1_rd_empty", 32'(bus.recieve_more_than_0), 32'h0);

    // Single write into empty: visible the next edge.
    cycle(1'b1, 16'hA1, 1'b0);
    check("t2_dout", 32'(bus.dout),                32'hA1);
    check("t2_m0",   32'(bus.recieve_more_than_0), 32'h1);
    check("t2_m1",   32'(bus.recieve_more_than_1), 32'h0);
    cycle(1'b0, '0, 1'b1);
    check("t2_empty", 32'(bus.recieve_more_than_0), 32'h0);

    // Back-to-back writes then zero-bubble reads.
    cycle(1'b1, 16'h1, 1'b0);
    cycle(1'b1, 16'h2, 1'b0);
    cycle(1'b1, 16'h3, 1'b0);
    check("t3_head1", 32'(bus.dout), 32'h1);
    cycle(1'b0, '0, 1'b1);
    check("t3_head2", 32'(bus.dout), 32'h2);
    cycle(1'b0, '0, 1'b1);
    check("t3_head3", 32'(bus.dout), 32'h3);
    cycle(1'b0, '0, 1'b1);
    check("t3_empty", 32'(bus.recieve_more_than_0), 32'h0);

    // Simultaneous read/write with one word queued.
    cycle(1'b1, 16'h5, 1'b0);
    cycle(1'b1, 16'h6, 1'b1);
    check("t4_dout", 32'(bus.dout),                32'h6);
    check("t4_m0",   32'(bus.recieve_more_than_0), 32'h1);
    check("t4_m1",   32'(bus.recieve_more_than_1), 32'h0);
    cycle(1'b0, '0, 1'b1);

    // Fill to capacity, overflow, pop-while-full, drain, then wrapping traffic.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, DW'(16'h10 + i), 1'b0);
      if (i == 2) check("t5_nf_at3", 32'(bus.nearly_full), 32'h0);
      if (i == 3) check("t5_nf_at4", 32'(bus.nearly_full), 32'h1);
      if (i == 3) check("t5_full_at4", 32'(bus.full), 32'h0);
    end
    check("t5_full_at5", 32'(bus.full), 32'h1);
    cycle(1'b1, 16'hEE, 1'b0);
    check("t5_full_drop", 32'(bus.full), 32'h1);
    check("t5_head_drop", 32'(bus.dout), 32'h10);
    cycle(1'b1, 16'hDD, 1'b1);
    check("t5_full_rdwr", 32'(bus.full),        32'h0);
    check("t5_nf_rdwr",   32'(bus.nearly_full), 32'h1);
    check("t5_head_rdwr", 32'(bus.dout),        32'h11);
    for (int i = 1; i < 5; i++) begin
      check("t5_drain", 32'(bus.dout), 32'(16'h10 + i));
      cycle(1'b0, '0, 1'b1);
    end
    check("t5_drained", 32'(bus.recieve_more_than_0), 32'h0);
    for (int i = 0; i < 30; i++)
      cycle((i % 5) != 4, DW'(16'h100 + i), (i % 3) == 2);
    for (int i = 0; i < 7; i++)
      cycle(1'b0, '0, 1'b1);
    check("t5_mix_empty", 32'(bus.recieve_more_than_0), 32'h0);

    // Asynchronous reset with data queued, then fresh write.
    cycle(1'b1, 16'h31, 1'b0);
    cycle(1'b1, 16'h32, 1'b0);
    cycle(1'b1, 16'h33, 1'b0);
    #2;
    reset = 1'b1;
    model.delete();
    #1;
    check("t6_m0_async",   32'(bus.recieve_more_than_0), 32'h0);
    check("t6_m1_async",   32'(bus.recieve_more_than_1), 32'h0);
    check("t6_dout_async", 32'(bus.dout),                32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 16'h7, 1'b0);
    check("t6_first", 32'(bus.dout),                32'h7);
    check("t6_m1",    32'(bus.recieve_more_than_1), 32'h0);
    cycle(1'b0, '0, 1'b1);
    check("t6_empty", 32'(bus.recieve_more_than_0), 32'h0);

    @(posedge clk);
    #1;
    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
